// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding, load-use / RAW interlock,
// branch redirect flushes, multicycle EX stall FSM and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int REGW   = 5,
  parameter int CNTW   = 32,
  parameter int FWD_EN = 1,
  parameter int MC_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] id_rs1_id,
  input  logic [REGW-1:0] id_rs2_id,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [REGW-1:0] ex_rs1_id,
  input  logic [REGW-1:0] ex_rs2_id,
  input  logic [REGW-1:0] ex_rdst_id,
  input  logic            ex_we_reg,
  input  logic            ex_mem_read,
  input  logic            ex_mc_start,
  input  logic            ex_redirect,
  input  logic [REGW-1:0] mem_rdst_id,
  input  logic [REGW-1:0] wb_rdst_id,
  input  logic            mem_we_reg,
  input  logic            wb_we_reg,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            idex_write,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            mc_busy,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam bit         MC_MULTI = (MC_LAT > 1);
  localparam logic [3:0] MC_LOAD  = 4'(MC_LAT - 2);

  state_e          state_q, state_d;
  logic [3:0]      mc_cnt_q, mc_cnt_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;
  logic            mc_busy_s;
  logic            raw_stall_s;

  // A producer only counts when it writes a non-zero register.
  function automatic logic hit(input logic we, input logic [REGW-1:0] rd,
                               input logic [REGW-1:0] x);
    return we && (rd == x) && (x != {REGW{1'b0}});
  endfunction

  // EX operand forwarding: youngest producer (MEM) wins over WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst || (FWD_EN == 0)) begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end else begin
      if (hit(mem_we_reg, mem_rdst_id, ex_rs1_id))     fwd_a = 2'b01;
      else if (hit(wb_we_reg, wb_rdst_id, ex_rs1_id))  fwd_a = 2'b10;
      else                                             fwd_a = 2'b00;
      if (hit(mem_we_reg, mem_rdst_id, ex_rs2_id))     fwd_b = 2'b01;
      else if (hit(wb_we_reg, wb_rdst_id, ex_rs2_id))  fwd_b = 2'b10;
      else                                             fwd_b = 2'b00;
    end
  end

  // RAW detection; without forwarding any in-flight EX/MEM producer blocks ID
  always_comb begin
    logic ex_hit_s;
    logic mem_hit_s;
    ex_hit_s  = (id_use_rs1 && hit(ex_we_reg, ex_rdst_id, id_rs1_id)) ||
                (id_use_rs2 && hit(ex_we_reg, ex_rdst_id, id_rs2_id));
    mem_hit_s = (id_use_rs1 && hit(mem_we_reg, mem_rdst_id, id_rs1_id)) ||
                (id_use_rs2 && hit(mem_we_reg, mem_rdst_id, id_rs2_id));
    raw_stall_s = 1'b0;
    if (FWD_EN == 0) begin
      raw_stall_s = ex_hit_s || mem_hit_s;
    end else begin
      raw_stall_s = ex_hit_s && ex_mem_read;
    end
  end

  // Multicycle FSM: busy is raised in the start cycle itself, so MC_LAT-1 stall cycles
  always_comb begin
    state_d   = state_q;
    mc_cnt_d  = mc_cnt_q;
    mc_busy_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_mc_start && MC_MULTI) begin
          mc_busy_s = 1'b1;
          state_d   = BUSY;
          mc_cnt_d  = MC_LOAD;
        end else begin
          state_d   = IDLE;
        end
      end
      BUSY: begin
        if (mc_cnt_q != 4'd0) begin
          mc_busy_s = 1'b1;
          mc_cnt_d  = mc_cnt_q - 4'd1;
        end else begin
          state_d   = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        mc_cnt_d = 4'd0;
      end
    endcase
  end

  // Stage enables / bubbles: mc_busy > redirect > RAW stall
  always_comb begin
    mc_busy     = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (rst) begin
      mc_busy = 1'b0;
    end else if (mc_busy_s) begin
      mc_busy     = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_flush = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (raw_stall_s) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else begin
      mc_busy = 1'b0;
    end
  end

  // Saturating counter next-state
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (ifid_flush && (flush_cnt_q != {CNTW{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNTW'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mc_cnt_q    <= 4'd0;
      stall_cnt_q <= {CNTW{1'b0}};
      flush_cnt_q <= {CNTW{1'b0}};
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: four parameterisations share one stimulus stream
// (default, interlock-only, 4-bit counters, single-cycle EX).
module tb_pipe_hazard_ctrl;
  localparam int REGW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [REGW-1:0] id_rs1_id, id_rs2_id, ex_rs1_id, ex_rs2_id, ex_rdst_id;
  logic [REGW-1:0] mem_rdst_id, wb_rdst_id;
  logic id_use_rs1, id_use_rs2, ex_we_reg, ex_mem_read, ex_mc_start, ex_redirect;
  logic mem_we_reg, wb_we_reg;

  logic m_pc_write, m_ifid_write, m_idex_write, m_ifid_flush, m_idex_flush, m_exmem_flush, m_mc_busy;
  logic [1:0] m_fwd_a, m_fwd_b;
  logic [31:0] m_stall_cnt, m_flush_cnt;
  logic n_pc_write, n_ifid_write, n_idex_write, n_ifid_flush, n_idex_flush, n_exmem_flush, n_mc_busy;
  logic [1:0] n_fwd_a, n_fwd_b;
  logic [31:0] n_stall_cnt, n_flush_cnt;
  logic c_pc_write, c_ifid_write, c_idex_write, c_ifid_flush, c_idex_flush, c_exmem_flush, c_mc_busy;
  logic [1:0] c_fwd_a, c_fwd_b;
  logic [3:0] c_stall_cnt, c_flush_cnt;
  logic s_pc_write, s_ifid_write, s_idex_write, s_ifid_flush, s_idex_flush, s_exmem_flush, s_mc_busy;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [31:0] s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REGW(REGW), .CNTW(32), .FWD_EN(1), .MC_LAT(4)) dut (
    .clk(clk), .rst(rst), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1_id(ex_rs1_id), .ex_rs2_id(ex_rs2_id),
    .ex_rdst_id(ex_rdst_id), .ex_we_reg(ex_we_reg), .ex_mem_read(ex_mem_read),
    .ex_mc_start(ex_mc_start), .ex_redirect(ex_redirect), .mem_rdst_id(mem_rdst_id),
    .wb_rdst_id(wb_rdst_id), .mem_we_reg(mem_we_reg), .wb_we_reg(wb_we_reg),
    .pc_write(m_pc_write), .ifid_write(m_ifid_write), .idex_write(m_idex_write),
    .ifid_flush(m_ifid_flush), .idex_flush(m_idex_flush), .exmem_flush(m_exmem_flush),
    .fwd_a(m_fwd_a), .fwd_b(m_fwd_b), .mc_busy(m_mc_busy),
    .stall_cnt(m_stall_cnt), .flush_cnt(m_flush_cnt));

  pipe_hazard_ctrl #(.REGW(REGW), .CNTW(32), .FWD_EN(0), .MC_LAT(4)) dut_nf (
    .clk(clk), .rst(rst), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1_id(ex_rs1_id), .ex_rs2_id(ex_rs2_id),
    .ex_rdst_id(ex_rdst_id), .ex_we_reg(ex_we_reg), .ex_mem_read(ex_mem_read),
    .ex_mc_start(ex_mc_start), .ex_redirect(ex_redirect), .mem_rdst_id(mem_rdst_id),
    .wb_rdst_id(wb_rdst_id), .mem_we_reg(mem_we_reg), .wb_we_reg(wb_we_reg),
    .pc_write(n_pc_write), .ifid_write(n_ifid_write), .idex_write(n_idex_write),
    .ifid_flush(n_ifid_flush), .idex_flush(n_idex_flush), .exmem_flush(n_exmem_flush),
    .fwd_a(n_fwd_a), .fwd_b(n_fwd_b), .mc_busy(n_mc_busy),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt));

  pipe_hazard_ctrl #(.REGW(REGW), .CNTW(4), .FWD_EN(1), .MC_LAT(4)) dut_c4 (
    .clk(clk), .rst(rst), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1_id(ex_rs1_id), .ex_rs2_id(ex_rs2_id),
    .ex_rdst_id(ex_rdst_id), .ex_we_reg(ex_we_reg), .ex_mem_read(ex_mem_read),
    .ex_mc_start(ex_mc_start), .ex_redirect(ex_redirect), .mem_rdst_id(mem_rdst_id),
    .wb_rdst_id(wb_rdst_id), .mem_we_reg(mem_we_reg), .wb_we_reg(wb_we_reg),
    .pc_write(c_pc_write), .ifid_write(c_ifid_write), .idex_write(c_idex_write),
    .ifid_flush(c_ifid_flush), .idex_flush(c_idex_flush), .exmem_flush(c_exmem_flush),
    .fwd_a(c_fwd_a), .fwd_b(c_fwd_b), .mc_busy(c_mc_busy),
    .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt));

  pipe_hazard_ctrl #(.REGW(REGW), .CNTW(32), .FWD_EN(1), .MC_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1_id(ex_rs1_id), .ex_rs2_id(ex_rs2_id),
    .ex_rdst_id(ex_rdst_id), .ex_we_reg(ex_we_reg), .ex_mem_read(ex_mem_read),
    .ex_mc_start(ex_mc_start), .ex_redirect(ex_redirect), .mem_rdst_id(mem_rdst_id),
    .wb_rdst_id(wb_rdst_id), .mem_we_reg(mem_we_reg), .wb_we_reg(wb_we_reg),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .idex_write(s_idex_write),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .mc_busy(s_mc_busy),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_rs1_id = 5'd0; id_rs2_id = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1_id = 5'd0; ex_rs2_id = 5'd0; ex_rdst_id = 5'd0; ex_we_reg = 1'b0;
    ex_mem_read = 1'b0; ex_mc_start = 1'b0; ex_redirect = 1'b0;
    mem_rdst_id = 5'd0; wb_rdst_id = 5'd0; mem_we_reg = 1'b0; wb_we_reg = 1'b0;
  endtask

  // EX load writes r5, ID reads r5 as rs2
  task automatic load_use();
    ex_we_reg = 1'b1; ex_mem_read = 1'b1; ex_rdst_id = 5'd5;
    id_rs2_id = 5'd5; id_use_rs2 = 1'b1;
  endtask

  initial begin
    clr();
    // reset asserted with hazards and mc_start present: outputs must be neutral
    #1 rst = 1'b1;
    load_use(); ex_mc_start = 1'b1;
    mem_we_reg = 1'b1; mem_rdst_id = 5'd3; ex_rs1_id = 5'd3;
    #1;
    chk("rst_mc_busy", m_mc_busy, 1'b0);
    chk("rst_pc_write", m_pc_write, 1'b1);
    chk("rst_ifid_write", m_ifid_write, 1'b1);
    chk("rst_idex_flush", m_idex_flush, 1'b0);
    chk("rst_exmem_flush", m_exmem_flush, 1'b0);
    chk("rst_fwd_a", m_fwd_a, 2'b00);
    chk("rst_stall_cnt", m_stall_cnt, 32'd0);
    chk("rst_flush_cnt", m_flush_cnt, 32'd0);
    @(posedge clk); #1;
    chk("rst_stall_cnt_edge", m_stall_cnt, 32'd0);
    @(negedge clk);
    clr(); rst = 1'b0;

    // load-use stall
    @(negedge clk);
    load_use();
    #1;
    chk("lu_pc_write", m_pc_write, 1'b0);
    chk("lu_ifid_write", m_ifid_write, 1'b0);
    chk("lu_idex_write", m_idex_write, 1'b1);
    chk("lu_idex_flush", m_idex_flush, 1'b1);
    chk("lu_ifid_flush", m_ifid_flush, 1'b0);
    chk("lu_nf_pc_write", n_pc_write, 1'b0);
    @(posedge clk); #1;
    chk("lu_stall_cnt", m_stall_cnt, 32'd1);
    chk("lu_flush_cnt", m_flush_cnt, 32'd0);
    @(negedge clk);
    clr(); #1;
    chk("lu_release_pc_write", m_pc_write, 1'b1);
    load_use(); ex_rdst_id = 5'd0; id_rs2_id = 5'd0; #1;
    chk("lu_r0_pc_write", m_pc_write, 1'b1);
    load_use(); id_use_rs2 = 1'b0; #1;
    chk("lu_unused_pc_write", m_pc_write, 1'b1);
    clr();

    // forwarding priority and r0 exclusion
    @(negedge clk);
    mem_we_reg = 1'b1; mem_rdst_id = 5'd3; wb_we_reg = 1'b1; wb_rdst_id = 5'd3;
    ex_rs1_id = 5'd3; ex_rs2_id = 5'd3; #1;
    chk("fwd_a_mem", m_fwd_a, 2'b01);
    chk("fwd_b_mem", m_fwd_b, 2'b01);
    chk("nf_fwd_a_mem", n_fwd_a, 2'b00);
    mem_rdst_id = 5'd0; #1;
    chk("fwd_a_wb", m_fwd_a, 2'b10);
    chk("fwd_b_wb", m_fwd_b, 2'b10);
    chk("nf_fwd_a_wb", n_fwd_a, 2'b00);
    clr(); #1;
    chk("fwd_a_none", m_fwd_a, 2'b00);

    // interlock-only: non-load EX producer and MEM producer both stall
    @(negedge clk);
    ex_we_reg = 1'b1; ex_rdst_id = 5'd7; id_rs1_id = 5'd7; id_use_rs1 = 1'b1; #1;
    chk("exalu_pc_write", m_pc_write, 1'b1);
    chk("nf_exalu_pc_write", n_pc_write, 1'b0);
    chk("nf_exalu_idex_flush", n_idex_flush, 1'b1);
    clr();
    mem_we_reg = 1'b1; mem_rdst_id = 5'd9; id_rs1_id = 5'd9; id_use_rs1 = 1'b1; #1;
    chk("memhit_pc_write", m_pc_write, 1'b1);
    chk("nf_memhit_pc_write", n_pc_write, 1'b0);
    clr();

    // redirect overrides a coincident load-use hit
    @(negedge clk);
    load_use(); ex_redirect = 1'b1; #1;
    chk("rd_ifid_flush", m_ifid_flush, 1'b1);
    chk("rd_idex_flush", m_idex_flush, 1'b1);
    chk("rd_pc_write", m_pc_write, 1'b1);
    chk("rd_ifid_write", m_ifid_write, 1'b1);
    chk("rd_idex_write", m_idex_write, 1'b1);
    @(posedge clk); #1;
    chk("rd_flush_cnt", m_flush_cnt, 32'd1);
    chk("rd_stall_cnt", m_stall_cnt, 32'd1);

    // multicycle op: 3 busy cycles then release while start still held
    @(negedge clk);
    clr(); ex_mc_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mc_busy", m_mc_busy, 1'b1);
      chk("mc_pc_write", m_pc_write, 1'b0);
      chk("mc_idex_write", m_idex_write, 1'b0);
      chk("mc_exmem_flush", m_exmem_flush, 1'b1);
      chk("mc_ifid_flush", m_ifid_flush, 1'b0);
      chk("mc_lat1_busy", s_mc_busy, 1'b0);
      @(negedge clk);
    end
    #1;
    chk("mc_done_busy", m_mc_busy, 1'b0);
    chk("mc_done_pc_write", m_pc_write, 1'b1);
    chk("mc_done_exmem_flush", m_exmem_flush, 1'b0);
    @(negedge clk);
    clr(); #1;
    chk("mc_idle_busy", m_mc_busy, 1'b0);
    chk("mc_stall_cnt", m_stall_cnt, 32'd4);
    chk("mc_lat1_stall_cnt", s_stall_cnt, 32'd1);

    // reset in the second busy cycle aborts; next start runs a full sequence
    @(negedge clk);
    ex_mc_start = 1'b1; #1;
    chk("ab_first_busy", m_mc_busy, 1'b1);
    @(negedge clk); #1;
    chk("ab_second_busy", m_mc_busy, 1'b1);
    rst = 1'b1; #1;
    chk("ab_rst_busy", m_mc_busy, 1'b0);
    chk("ab_rst_pc_write", m_pc_write, 1'b1);
    chk("ab_rst_exmem_flush", m_exmem_flush, 1'b0);
    chk("ab_rst_stall_cnt", m_stall_cnt, 32'd0);
    chk("ab_rst_flush_cnt", m_flush_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ab_restart_busy", m_mc_busy, 1'b1);
      @(negedge clk);
    end
    #1;
    chk("ab_restart_done", m_mc_busy, 1'b0);
    clr();
    @(posedge clk); #1;
    chk("ab_stall_cnt", m_stall_cnt, 32'd3);
    chk("ab_c4_stall_cnt", c_stall_cnt, 4'd3);

    // 20 load-use stalls then 20 redirects: 4-bit counters saturate at 15
    @(negedge clk);
    load_use();
    repeat (20) @(negedge clk);
    #1;
    chk("sat_c4_stall_cnt", c_stall_cnt, 4'd15);
    chk("sat_stall_cnt", m_stall_cnt, 32'd23);
    clr(); ex_redirect = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("sat_c4_flush_cnt", c_flush_cnt, 4'd15);
    chk("sat_flush_cnt", m_flush_cnt, 32'd20);
    chk("sat_c4_stall_hold", c_stall_cnt, 4'd15);
    clr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
